memwb_elastic_stage: RTL and testbench
======================================

// Module: memwb_elastic_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
//  Sits between the memory stage and register-file write-back.
//  Carries control word, result data and destination register.
//  Produces qualified RF/HI/LO write enables and a forwarding tap; supports stall and flush.
// PARAMETERS
//  CTRL_W     17  width of control word
//  DATA_W     32  width of result data
//  REG_AW     5   destination register address width
//  RF_EN_BIT  9   control bit index: register-file write enable
//  HI_EN_BIT  2   control bit index: HI write enable
//  LO_EN_BIT  1   control bit index: LO write enable
//  ZERO_GUARD 1   1 = suppress rf_we when dest==0
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-high reset
//  flush       in   1        sync flush: discard all held entries
//  in_valid    in   1        upstream entry valid
//  in_ready    out  1        stage can accept (registered)
//  in_ctrl     in   CTRL_W   control word from MEM
//  in_result   in   DATA_W   ALU/memory result
//  in_dest     in   REG_AW   destination register
//  out_valid   out  1        head entry valid
//  out_ready   in   1        write-back consumes head this cycle
//  out_ctrl    out  CTRL_W   head control word
//  out_result  out  DATA_W   head result
//  out_dest    out  REG_AW   head destination
//  rf_we       out  1        out_valid & out_ready & ctrl[RF_EN_BIT] (& dest!=0 if ZERO_GUARD)
//  hi_we       out  1        out_valid & out_ready & ctrl[HI_EN_BIT]
//  lo_we       out  1        out_valid & out_ready & ctrl[LO_EN_BIT]
//  fwd_valid   out  1        out_valid & ctrl[RF_EN_BIT] (& dest!=0 if ZERO_GUARD)
//  fwd_dest    out  REG_AW   = out_dest
//  fwd_data    out  DATA_W   = out_result
// BEHAVIOUR
//  - Storage: main slot (drives out_*), skid slot; each has a valid bit. Occupancy 0/1/2.
//  - Reset: both valid bits 0, all payload regs 0, in_ready=1; all outputs 0.
//  - accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - Occupancy 0: accept -> main; out_valid=1 next cycle (latency 1).
//  - Occupancy 1: accept & pop -> main<=input; accept & !pop -> skid<=input;
//    pop & !accept -> empty.
//  - Occupancy 2: in_ready=0; pop -> main<=skid, skid empty, in_ready=1 next cycle.
//  - in_ready registered: next = !(next occupancy == 2).
//  - Order strictly FIFO; no entry dropped or duplicated except by flush.
//  - flush: highest priority; next cycle both valids 0, in_ready 1;
//    entry accepted in flush cycle discarded; pop in flush cycle still completes
//    (write enables still asserted that cycle).
//  - Payload regs not cleared on flush (don't-care when invalid); out_valid=0 masks enables.
//  - Enables combinational from head; never asserted when out_valid=0.
//  - out_ctrl/out_result/out_dest stable while out_valid & !out_ready.
//  - Reset mid-operation: immediate clear regardless of clk; in-flight entries lost.
// TESTING
//  1. reset, in_valid=1 ctrl[9]=1 dest=5 result=0xDEAD, out_ready=1
//     -> next cycle out_valid=1, rf_we=1, fwd_dest=5, fwd_data=0xDEAD.
//  2. out_ready=0, push A,B -> in_ready=0 after B; hold 3 cycles, out=A stable;
//     out_ready=1 -> A then B; in_ready=1.
//  3. dest=0, ctrl[9]=1, ZERO_GUARD=1 -> rf_we=0, fwd_valid=0; ctrl[2]=1 -> hi_we=1.
//  4. occupancy 2 + flush with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     no enables afterwards.
//  5. reset asserted mid-stream between clk edges -> out_valid, in_ready-gated
//     enables 0 immediately; in_ready=1.
//  6. 1000-cycle random in_valid/out_ready -> output sequence equals input
//     sequence (scoreboard), no loss.

Source files
------------

// File: rtl/memwb_elastic_stage.sv
// MEM/WB elastic pipeline stage.
// Holds up to two entries (main slot + skid slot) between the memory stage
// and register-file write-back. The main slot always holds the oldest entry
// and drives the out_* bus, the write enables and the forwarding tap.
//
// Handshake: an entry moves on an edge where valid and ready are both high.
// Upstream: accept = in_valid & in_ready. Downstream: pop = out_valid & out_ready.
// A producer holding valid may not retract it. The stage keeps out_* stable
// while out_valid & !out_ready. in_ready is a register, so upstream never
// sees a combinational path from out_ready.
module memwb_elastic_stage #(
  parameter int CTRL_W     = 17,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int RF_EN_BIT  = 9,
  parameter int HI_EN_BIT  = 2,
  parameter int LO_EN_BIT  = 1,
  parameter int ZERO_GUARD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_AW-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_dest,
  output logic              rf_we,
  output logic              hi_we,
  output logic              lo_we,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
);

  // Current state
  logic              main_valid;
  logic              skid_valid;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_result;
  logic [REG_AW-1:0] main_dest;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_result;
  logic [REG_AW-1:0] skid_dest;

  // Next state
  logic              main_valid_n;
  logic              skid_valid_n;
  logic              in_ready_n;
  logic [CTRL_W-1:0] main_ctrl_n;
  logic [DATA_W-1:0] main_result_n;
  logic [REG_AW-1:0] main_dest_n;
  logic [CTRL_W-1:0] skid_ctrl_n;
  logic [DATA_W-1:0] skid_result_n;
  logic [REG_AW-1:0] skid_dest_n;

  logic accept;
  logic pop;
  logic dest_ok;
  logic rf_en;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid & out_ready;

  // Next-state for valid bits, payload slots and the registered in_ready.
  always_comb begin
    main_valid_n  = main_valid;
    skid_valid_n  = skid_valid;
    main_ctrl_n   = main_ctrl;
    main_result_n = main_result;
    main_dest_n   = main_dest;
    skid_ctrl_n   = skid_ctrl;
    skid_result_n = skid_result;
    skid_dest_n   = skid_dest;

    if (flush) begin
      // Flush wins over everything. A pop in this cycle has already been
      // seen by write-back through the enables; an accept is dropped.
      // Payload registers keep their stale contents; invalid makes them
      // don't-care.
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      case ({main_valid, skid_valid})
        2'b00: begin
          // Empty: a new entry goes straight to the head.
          if (accept) begin
            main_valid_n  = 1'b1;
            main_ctrl_n   = in_ctrl;
            main_result_n = in_result;
            main_dest_n   = in_dest;
          end
        end
        2'b10: begin
          // One entry: pass-through, park in skid, or drain.
          if (accept && pop) begin
            main_ctrl_n   = in_ctrl;
            main_result_n = in_result;
            main_dest_n   = in_dest;
          end else if (accept) begin
            skid_valid_n  = 1'b1;
            skid_ctrl_n   = in_ctrl;
            skid_result_n = in_result;
            skid_dest_n   = in_dest;
          end else if (pop) begin
            main_valid_n  = 1'b0;
          end
        end
        2'b11: begin
          // Full: in_ready is low, so only a pop can change anything.
          // The skid entry is younger and moves up to the head.
          if (pop) begin
            skid_valid_n  = 1'b0;
            main_ctrl_n   = skid_ctrl;
            main_result_n = skid_result;
            main_dest_n   = skid_dest;
          end
        end
        default: begin
          // Skid-only cannot be reached; if it ever happens, recover by
          // promoting the skid entry so nothing is lost.
          main_valid_n  = 1'b1;
          skid_valid_n  = 1'b0;
          main_ctrl_n   = skid_ctrl;
          main_result_n = skid_result;
          main_dest_n   = skid_dest;
        end
      endcase
    end

    // Ready only drops when both slots will be occupied.
    in_ready_n = ~(main_valid_n & skid_valid_n);
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl   <= '0;
      main_result <= '0;
      main_dest   <= '0;
      skid_ctrl   <= '0;
      skid_result <= '0;
      skid_dest   <= '0;
    end else begin
      main_valid  <= main_valid_n;
      skid_valid  <= skid_valid_n;
      in_ready_q  <= in_ready_n;
      main_ctrl   <= main_ctrl_n;
      main_result <= main_result_n;
      main_dest   <= main_dest_n;
      skid_ctrl   <= skid_ctrl_n;
      skid_result <= skid_result_n;
      skid_dest   <= skid_dest_n;
    end
  end

  // Head-of-queue outputs, qualified write enables and forwarding tap.
  always_comb begin
    dest_ok    = (ZERO_GUARD == 0) || (main_dest != '0);
    rf_en      = main_ctrl[RF_EN_BIT] & dest_ok;

    in_ready   = in_ready_q;
    out_valid  = main_valid;
    out_ctrl   = main_ctrl;
    out_result = main_result;
    out_dest   = main_dest;

    rf_we      = pop & rf_en;
    hi_we      = pop & main_ctrl[HI_EN_BIT];
    lo_we      = pop & main_ctrl[LO_EN_BIT];

    fwd_valid  = main_valid & rf_en;
    fwd_dest   = main_dest;
    fwd_data   = main_result;
  end

endmodule

// File: tb/tb_memwb_elastic_stage.sv
// Bench for memwb_elastic_stage: directed scenarios plus a random stream,
// with a recorder pushing accepted entries into an expected queue and a
// monitor comparing every presented head against it.
module tb_memwb_elastic_stage;

  localparam int CW = 17;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = CW + DW + AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_result = '0;
  logic [AW-1:0] in_dest = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_result;
  logic [AW-1:0] out_dest;
  logic          rf_we, hi_we, lo_we, fwd_valid;
  logic [AW-1:0] fwd_dest;
  logic [DW-1:0] fwd_data;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  memwb_elastic_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_result(in_result), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_result(out_result), .out_dest(out_dest),
    .rf_we(rf_we), .hi_we(hi_we), .lo_we(lo_we),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for a single cycle, then withdraw in_valid.
  task automatic drive(input logic [CW-1:0] c, input logic [DW-1:0] r,
                       input logic [AW-1:0] d, input logic ordy);
    in_valid  = 1'b1;
    in_ctrl   = c;
    in_result = r;
    in_dest   = d;
    out_ready = ordy;
    step();
    in_valid  = 1'b0;
  endtask

  // Recorder: an entry accepted on the coming edge joins the expected queue,
  // unless a flush discards it in the same cycle.
  always @(negedge clk) begin
    if (!reset && !flush && in_valid && in_ready)
      exp_q.push_back({in_ctrl, in_result, in_dest});
  end

  // Flush and reset empty the stage, so the expectation empties too.
  always @(posedge clk) begin
    if (!reset && flush) exp_q.delete();
  end

  always @(posedge reset) exp_q.delete();

  // Monitor: compare the head and its enables against the expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          logic [EW-1:0] e;
          logic [CW-1:0] ec;
          logic [AW-1:0] ed;
          logic          erf;
          e   = exp_q[0];
          ec  = e[EW-1 -: CW];
          ed  = e[AW-1:0];
          erf = ec[9] && (ed != 0);
          check("out_ctrl", out_ctrl, ec);
          check("out_result", out_result, e[AW +: DW]);
          check("out_dest", out_dest, ed);
          check("rf_we", rf_we, erf && out_ready);
          check("hi_we", hi_we, ec[2] && out_ready);
          check("lo_we", lo_we, ec[1] && out_ready);
          check("fwd_valid", fwd_valid, erf);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_enables", {rf_we, hi_we, lo_we, fwd_valid}, 4'b0000);
      end
    end
  end

  initial begin
    // Test 1: reset state and single-entry latency
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_ctrl", out_ctrl, '0);
    check("rst_out_result", out_result, '0);
    check("rst_enables", {rf_we, hi_we, lo_we, fwd_valid}, 4'b0000);
    reset = 1'b0;
    step();
    drive(17'h00200, 32'h0000DEAD, 5'd5, 1'b1);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_rf_we", rf_we, 1'b1);
    check("t1_fwd_dest", fwd_dest, 5'd5);
    check("t1_fwd_data", fwd_data, 32'h0000DEAD);
    step();
    check("t1_drained", out_valid, 1'b0);

    // Test 2: back-pressure fills skid, head holds stable, FIFO drain
    drive(17'h00200, 32'hAAAA0001, 5'd1, 1'b0);
    check("t2_ready_after_a", in_ready, 1'b1);
    drive(17'h00200, 32'hBBBB0002, 5'd2, 1'b0);
    check("t2_ready_full", in_ready, 1'b0);
    repeat (3) step();
    check("t2_hold_head", out_result, 32'hAAAA0001);
    check("t2_hold_rf_we", rf_we, 1'b0);
    out_ready = 1'b1;
    step();
    check("t2_second_head", out_result, 32'hBBBB0002);
    check("t2_ready_back", in_ready, 1'b1);
    step();
    check("t2_empty", out_valid, 1'b0);

    // Test 3: zero-destination guard and HI/LO enables
    drive(17'h00204, 32'h00001234, 5'd0, 1'b1);
    check("t3_rf_we_guard", rf_we, 1'b0);
    check("t3_fwd_guard", fwd_valid, 1'b0);
    check("t3_hi_we", hi_we, 1'b1);
    check("t3_lo_we", lo_we, 1'b0);
    drive(17'h00002, 32'h00005678, 5'd7, 1'b1);
    check("t3_lo_we2", lo_we, 1'b1);
    check("t3_rf_we2", rf_we, 1'b0);
    step();

    // Test 4: flush with full stage and an incoming entry
    drive(17'h00200, 32'hC0000001, 5'd3, 1'b0);
    drive(17'h00200, 32'hC0000002, 5'd4, 1'b0);
    in_valid  = 1'b1;
    in_result = 32'hC0000003;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("t4_flush_valid", out_valid, 1'b0);
    check("t4_flush_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("t4_post_flush_rf", {rf_we, out_valid}, 2'b00);
    end

    // Test 4b: a pop in the flush cycle still writes back
    drive(17'h00200, 32'hD0000001, 5'd6, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check("t4b_flush_pop_rf", rf_we, 1'b1);
    step();
    flush = 1'b0;
    check("t4b_after", out_valid, 1'b0);

    // Test 5: asynchronous reset between clock edges
    drive(17'h00200, 32'hE0000001, 5'd8, 1'b0);
    drive(17'h00200, 32'hE0000002, 5'd9, 1'b0);
    out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_in_ready", in_ready, 1'b1);
    check("t5_enables", {rf_we, hi_we, lo_we, fwd_valid}, 4'b0000);
    step();
    reset = 1'b0;
    step();
    check("t5_stays_empty", out_valid, 1'b0);

    // Test 6: random valid/ready stream against the scoreboard
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_ctrl   = CW'($urandom);
      in_result = $urandom;
      in_dest   = AW'($urandom_range(0, 31));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("t6_drain_empty", exp_q.size(), 0);
    check("t6_out_idle", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
